// File: rtl/alu24_pkg.sv
// Shared constants and types for the 24-bit ALU sequencing controller.
// Holds operation codes, ALU op encodings, the FSM state type and datapath width.
package alu24_pkg;

    localparam int WIDTH     = 24;
    localparam int MUL_STEPS = 24;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0011;
    localparam logic [3:0] CTL_SLT = 4'b0100;
    localparam logic [3:0] CTL_SLL = 4'b0101;
    localparam logic [3:0] CTL_MUL = 4'b1000;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu24_ctl_decode.sv
// Combinational decode of a 4-bit operation code into ALU control.
// MUL decodes to the ADD path since each shift-add step is an ALU add.
module alu24_ctl_decode
    import alu24_pkg::*;
(
    input  logic [3:0] ctl,
    output logic [2:0] op,
    output logic       bnegate,
    output logic       is_mul,
    output logic       legal
);

    always_comb begin
        op      = OP_AND;
        bnegate = 1'b0;
        is_mul  = 1'b0;
        legal   = 1'b1;
        case (ctl)
            CTL_AND: op = OP_AND;
            CTL_OR:  op = OP_OR;
            CTL_ADD: op = OP_ADD;
            CTL_SUB: begin
                op      = OP_ADD;
                bnegate = 1'b1;
            end
            CTL_SLT: begin
                op      = OP_SLT;
                bnegate = 1'b1;
            end
            CTL_SLL: op = OP_SLL;
            CTL_MUL: begin
                op     = OP_ADD;
                is_mul = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu24_seq_ctrl.sv
// Initiator for an external combinational 24-bit ALU: issues one operation per
// request, runs MUL as 24 shift-add steps, and returns registered result/flags.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds with its payload stable until that edge.
module alu24_seq_ctrl
    import alu24_pkg::*;
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [3:0]       InCtl,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic [3:0]       InShamt,
    output logic [WIDTH-1:0] AluA,
    output logic [WIDTH-1:0] AluB,
    output logic             AluBNegate,
    output logic [2:0]       AluOp,
    output logic [3:0]       AluShamt,
    input  logic [WIDTH-1:0] AluResult,
    input  logic             AluZero,
    input  logic             AluOverflow,
    input  logic             AluCarryOut,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutResult,
    output logic             OutZero,
    output logic             OutOverflow,
    output logic             OutCarry,
    output logic             OutIllegal
);

    localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

    // State is kept as a named signal so checkers can bind to it directly.
    state_t state, state_next;

    logic [2:0]       dec_op;
    logic             dec_bneg, dec_is_mul, dec_legal;

    logic [2:0]       op_q;
    logic             bneg_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [3:0]       shamt_q;

    logic [WIDTH-1:0] p_q, m_q, q_q, p_next;
    logic [4:0]       step_q;
    logic             carry_sticky_q, carry_step;

    logic [WIDTH-1:0] res_q;
    logic             zero_q, ovf_q, carry_q, illegal_q;

    alu24_ctl_decode u_decode (
        .ctl     (InCtl),
        .op      (dec_op),
        .bnegate (dec_bneg),
        .is_mul  (dec_is_mul),
        .legal   (dec_legal)
    );

    assign p_next     = q_q[0] ? AluResult : p_q;
    assign carry_step = q_q[0] & AluCarryOut;

    always_comb begin
        state_next = state;
        InReady    = 1'b0;
        AluA       = '0;
        AluB       = '0;
        AluBNegate = 1'b0;
        AluOp      = OP_AND;
        AluShamt   = '0;
        case (state)
            IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    if (!dec_legal)     state_next = DONE;
                    else if (dec_is_mul) state_next = MUL;
                    else                state_next = EXEC;
                end
            end
            EXEC: begin
                AluA       = a_q;
                AluB       = b_q;
                AluShamt   = shamt_q;
                AluOp      = op_q;
                AluBNegate = bneg_q;
                state_next = DONE;
            end
            MUL: begin
                AluA  = p_q;
                AluB  = m_q;
                AluOp = OP_ADD;
                if (step_q == LAST_STEP) state_next = DONE;
            end
            DONE: begin
                if (OutReady) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // During reset the ALU sees a quiet bus and no request is accepted.
        if (Reset) begin
            InReady    = 1'b0;
            AluA       = '0;
            AluB       = '0;
            AluBNegate = 1'b0;
            AluOp      = OP_AND;
            AluShamt   = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state          <= IDLE;
            op_q           <= OP_AND;
            bneg_q         <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            shamt_q        <= '0;
            p_q            <= '0;
            m_q            <= '0;
            q_q            <= '0;
            step_q         <= '0;
            carry_sticky_q <= 1'b0;
            res_q          <= '0;
            zero_q         <= 1'b0;
            ovf_q          <= 1'b0;
            carry_q        <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (InValid) begin
                        op_q           <= dec_op;
                        bneg_q         <= dec_bneg;
                        a_q            <= InA;
                        b_q            <= InB;
                        shamt_q        <= InShamt;
                        p_q            <= '0;
                        m_q            <= InA;
                        q_q            <= InB;
                        step_q         <= '0;
                        carry_sticky_q <= 1'b0;
                        if (!dec_legal) begin
                            res_q     <= '0;
                            zero_q    <= 1'b1;
                            ovf_q     <= 1'b0;
                            carry_q   <= 1'b0;
                            illegal_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res_q     <= AluResult;
                    zero_q    <= AluZero;
                    ovf_q     <= AluOverflow;
                    carry_q   <= AluCarryOut;
                    illegal_q <= 1'b0;
                end
                MUL: begin
                    p_q            <= p_next;
                    carry_sticky_q <= carry_sticky_q | carry_step;
                    m_q            <= m_q << 1;
                    q_q            <= q_q >> 1;
                    step_q         <= step_q + 5'd1;
                    // The final step's accumulate feeds the result directly.
                    if (step_q == LAST_STEP) begin
                        res_q     <= p_next;
                        zero_q    <= (p_next == '0);
                        ovf_q     <= 1'b0;
                        carry_q   <= carry_sticky_q | carry_step;
                        illegal_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign OutValid    = (state == DONE);
    assign OutResult   = res_q;
    assign OutZero     = zero_q;
    assign OutOverflow = ovf_q;
    assign OutCarry    = carry_q;
    assign OutIllegal  = illegal_q;

endmodule
